jlsemi_util_sync_filter_multi: RTL and testbench

Multi-channel asynchronous-input synchronizer with per-channel glitch filter and edge-pulse outputs. It is the next generation of the single-bit reset-low synchronizer. It adds channel count, a per-channel reset value, a programmable stability filter and registered rise/fall detection. It sits at the boundary where slow asynchronous status/strap/GPIO levels enter the `clk` domain.

---
 rtl/jlsemi_util_pkg.sv | 18 +
 rtl/jlsemi_util_sync_filter_ch.sv | 105 ++++++++++
 rtl/jlsemi_util_sync_filter_multi.sv | 52 +++++
 tb/tb_jlsemi_util_sync_filter_multi.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/jlsemi_util_pkg.sv
// Shared helpers for the jlsemi utility blocks.
package jlsemi_util_pkg;

  // Number of bits needed to encode values 0..value-1 (ceil(log2(value))).
  // A value of 0 or 1 yields 0; callers size counters with clog2(N+1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned res;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage : jlsemi_util_pkg

// File: rtl/jlsemi_util_sync_filter_ch.sv
// One channel of the multi-channel synchronizer: a SYNC_STEP-deep
// synchronizer chain, a stability filter that only lets dout follow the
// synchronized level after FILT_CNT consecutive mismatching cycles, and
// registered rise/fall pulses aligned with the dout change.
module jlsemi_util_sync_filter_ch
  import jlsemi_util_pkg::*;
#(
  parameter int unsigned SYNC_STEP = 2,
  parameter logic        RST_BIT   = 1'b0,
  parameter int unsigned FILT_CNT  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic filt_en,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CNT_W    = clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  // Last synchronizer stage, the first point where din is safe to use.
  logic sq;

`ifdef JL_SYNTHESIS
  // Library synchronizer cell with dont-touch attributes so the flops are
  // kept together, placed close and never retimed or merged.
  jlsemi_util_sync_cell_dt #(
    .STAGES  (SYNC_STEP),
    .RST_VAL (RST_BIT)
  ) u_sync_dt (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (sq)
  );
`else
  logic [SYNC_STEP-1:0] sync_q;
  logic [SYNC_STEP-1:0] sync_d;

  // Shift the asynchronous level in at bit 0; the MSB is the output stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STEP-2:0], din};
  end

  // Synchronizer flops; reset to the channel's idle level so a din that
  // already equals RST_BIT produces no edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STEP{RST_BIT}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sq = sync_q[SYNC_STEP-1];
`endif

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dout_q;
  logic             dout_d;
  logic             rise_q;
  logic             fall_q;

  // Stability filter: count consecutive cycles where sq disagrees with
  // dout; commit sq on the FILT_CNT-th such cycle. Any agreement, or the
  // bypass mode, clears the count so a new mismatch always starts at 0.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (!filt_en) begin
      dout_d = sq;
    end else if (sq != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = sq;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output state; edge pulses are derived from the next dout so they rise
  // in the same cycle the registered dout changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= RST_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= ~dout_q & dout_d;
      fall_q <= dout_q & ~dout_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule : jlsemi_util_sync_filter_ch

// File: rtl/jlsemi_util_sync_filter_multi.sv
// Multi-channel asynchronous-level synchronizer with per-channel glitch
// filter and rise/fall pulse outputs. Each channel is an independent
// instance of jlsemi_util_sync_filter_ch; filt_en is shared.
module jlsemi_util_sync_filter_multi
  import jlsemi_util_pkg::*;
#(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       SYNC_STEP = 2,
  parameter logic [NUM_CH-1:0] RST_VAL   = {NUM_CH{1'b0}},
  parameter int unsigned       FILT_CNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] din,
  input  logic              filt_en,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  // Width of each channel's filter counter; derived, never overridden.
  localparam int unsigned CNT_W = clog2(FILT_CNT + 1);

  // Reject configurations the channel logic is not built for.
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("jlsemi_util_sync_filter_multi: NUM_CH must be 1..32");
  end
  if (SYNC_STEP < 2 || SYNC_STEP > 4) begin : g_bad_sync_step
    $error("jlsemi_util_sync_filter_multi: SYNC_STEP must be 2..4");
  end
  if (FILT_CNT < 1 || FILT_CNT > 255 || CNT_W > 8) begin : g_bad_filt_cnt
    $error("jlsemi_util_sync_filter_multi: FILT_CNT must be 1..255");
  end

  // One fully independent synchronizer/filter per channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    jlsemi_util_sync_filter_ch #(
      .SYNC_STEP (SYNC_STEP),
      .RST_BIT   (RST_VAL[g]),
      .FILT_CNT  (FILT_CNT)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din[g]),
      .filt_en (filt_en),
      .dout    (dout[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

endmodule : jlsemi_util_sync_filter_multi

// File: tb/tb_jlsemi_util_sync_filter_multi.sv
// Directed bench for jlsemi_util_sync_filter_multi. Main instance:
// NUM_CH=4, SYNC_STEP=2, FILT_CNT=4, RST_VAL=4'b0101. Second instance:
// NUM_CH=1, SYNC_STEP=3, FILT_CNT=1. Inputs change 1 ns after a rising
// edge; outputs are checked 1 ns after the edge. "Edge 1" is the first
// edge that samples a newly applied din.
module tb_jlsemi_util_sync_filter_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic       filt_en;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;

  logic [0:0] din2;
  logic       filt_en2;
  logic [0:0] dout2;
  logic [0:0] rise2;
  logic [0:0] fall2;

  int n_cmp;
  int n_fail;

  jlsemi_util_sync_filter_multi #(
    .NUM_CH    (4),
    .SYNC_STEP (2),
    .RST_VAL   (4'b0101),
    .FILT_CNT  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .filt_en (filt_en),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall)
  );

  jlsemi_util_sync_filter_multi #(
    .NUM_CH    (1),
    .SYNC_STEP (3),
    .RST_VAL   (1'b0),
    .FILT_CNT  (1)
  ) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din2),
    .filt_en (filt_en2),
    .dout    (dout2),
    .rise    (rise2),
    .fall    (fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic       fe;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] d, input logic fe, input logic [3:0] o,
                     input logic [3:0] r, input logic [3:0] f, input int n);
    vec_t v;
    v.din  = d;
    v.fe   = fe;
    v.dout = o;
    v.rise = r;
    v.fall = f;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    din      = 4'b1010;
    filt_en  = 1'b1;
    din2     = 1'b0;
    filt_en2 = 1'b1;

    // Vector table: {din, filt_en, expected dout, rise, fall} per edge.
    // Filtered rise on ch1: dout changes at edge 6.
    add(4'h7, 1, 4'h5, 4'h0, 4'h0, 5);
    add(4'h7, 1, 4'h7, 4'h2, 4'h0, 1);
    add(4'h7, 1, 4'h7, 4'h0, 4'h0, 2);
    // 3-cycle glitch on ch3 is suppressed.
    add(4'hF, 1, 4'h7, 4'h0, 4'h0, 3);
    add(4'h7, 1, 4'h7, 4'h0, 4'h0, 5);
    // 4-cycle pulse on ch3 passes (rise at 6), then its fall is filtered too.
    add(4'hF, 1, 4'h7, 4'h0, 4'h0, 4);
    add(4'h7, 1, 4'h7, 4'h0, 4'h0, 1);
    add(4'h7, 1, 4'hF, 4'h8, 4'h0, 1);
    add(4'h7, 1, 4'hF, 4'h0, 4'h0, 3);
    add(4'h7, 1, 4'h7, 4'h0, 4'h8, 1);
    add(4'h7, 1, 4'h7, 4'h0, 4'h0, 1);
    // Bypass: ch2 toggles every 2 cycles, dout follows at edge 3.
    add(4'h3, 0, 4'h7, 4'h0, 4'h0, 2);
    add(4'h7, 0, 4'h3, 4'h0, 4'h4, 1);
    add(4'h7, 0, 4'h3, 4'h0, 4'h0, 1);
    add(4'h3, 0, 4'h7, 4'h4, 4'h0, 1);
    add(4'h3, 0, 4'h7, 4'h0, 4'h0, 1);
    add(4'h7, 0, 4'h3, 4'h0, 4'h4, 1);
    add(4'h7, 0, 4'h3, 4'h0, 4'h0, 1);
    add(4'h7, 0, 4'h7, 4'h4, 4'h0, 1);
    add(4'h7, 0, 4'h7, 4'h0, 4'h0, 2);
    // ch0 fall mid-count, filt_en dropped at edge 5: dout takes sq there.
    add(4'h6, 1, 4'h7, 4'h0, 4'h0, 4);
    add(4'h6, 0, 4'h6, 4'h0, 4'h1, 1);
    add(4'h6, 1, 4'h6, 4'h0, 4'h0, 2);
    // Re-enabled filter counts from 0: ch0 rise at edge 6.
    add(4'h7, 1, 4'h6, 4'h0, 4'h0, 5);
    add(4'h7, 1, 4'h7, 4'h1, 4'h0, 1);
    add(4'h7, 1, 4'h7, 4'h0, 4'h0, 2);
    // Back to 0101 (ch1 fall), then 0101 -> 1010 on all channels at once.
    add(4'h5, 1, 4'h7, 4'h0, 4'h0, 5);
    add(4'h5, 1, 4'h5, 4'h0, 4'h2, 1);
    add(4'h5, 1, 4'h5, 4'h0, 4'h0, 2);
    add(4'hA, 1, 4'h5, 4'h0, 4'h0, 5);
    add(4'hA, 1, 4'hA, 4'hA, 4'h5, 1);
    add(4'hA, 1, 4'hA, 4'h0, 4'h0, 2);

    // Reset with din opposite to RST_VAL.
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_state", {4'h0, dout, rise, fall}, {4'h0, 4'h5, 4'h0, 4'h0});
    chk("rst_state2", {13'h0, dout2, rise2, fall2}, 16'h0);

    // Release with din == RST_VAL: dout stable, no pulses for 50 cycles.
    din   = 4'b0101;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("rst_quiet", {4'h0, dout, rise, fall}, {4'h0, 4'h5, 4'h0, 4'h0});
    end

    // Table-driven section.
    for (int i = 0; i < tbl.size(); i++) begin
      din     = tbl[i].din;
      filt_en = tbl[i].fe;
      tick();
      chk($sformatf("vec%0d", i), {4'h0, dout, rise, fall},
          {4'h0, tbl[i].dout, tbl[i].rise, tbl[i].fall});
    end

    // Asynchronous reset from dout=1010 takes effect between edges.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {4'h0, dout, rise, fall}, {4'h0, 4'h5, 4'h0, 4'h0});
    din = 4'b0101;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst2_quiet", {4'h0, dout, rise, fall}, {4'h0, 4'h5, 4'h0, 4'h0});
    end

    // Reset mid-count on ch1 (between edges 4 and 5), then full latency again.
    din = 4'b0111;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("midcnt_e%0d", i), {4'h0, dout, rise, fall}, {4'h0, 4'h5, 4'h0, 4'h0});
    end
    #4;
    rst_n = 1'b0;
    #1;
    chk("midcnt_rst", {4'h0, dout, rise, fall}, {4'h0, 4'h5, 4'h0, 4'h0});
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i < 6)
        chk($sformatf("post_rst_e%0d", i), {4'h0, dout, rise, fall}, {4'h0, 4'h5, 4'h0, 4'h0});
      else if (i == 6)
        chk("post_rst_e6", {4'h0, dout, rise, fall}, {4'h0, 4'h7, 4'h2, 4'h0});
      else
        chk("post_rst_e7", {4'h0, dout, rise, fall}, {4'h0, 4'h7, 4'h0, 4'h0});
    end

    // Second instance: SYNC_STEP=3, FILT_CNT=1 -> dout changes at edge 4.
    din2 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("ch1cfg_rise_e%0d", i), {13'h0, dout2, rise2, fall2},
          (i < 4) ? 16'h0 : ((i == 4) ? 16'h6 : 16'h4));
    end
    din2 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("ch1cfg_fall_e%0d", i), {13'h0, dout2, rise2, fall2},
          (i < 4) ? 16'h4 : ((i == 4) ? 16'h1 : 16'h0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_jlsemi_util_sync_filter_multi
